// File: rtl/mips_cpu_bus_branch_unit.sv
// Registered branch/jump resolution with delay-slot sequencing and a stall-aware redirect.
// Optional return-address stack checking JR $31 targets is built when BRANCH_RAS_EN is defined.
module mips_cpu_bus_branch_unit #(
  parameter int XLEN        = 32,
  parameter int DELAY_SLOTS = 1,
  parameter int RAS_DEPTH   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic            stall,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  output logic            link_en,
  output logic [4:0]      link_dest,
  output logic [XLEN-1:0] link_data,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            slot_pending,
  output logic            addr_err,
  output logic            slot_err,
  output logic            ras_mispredict,
  output logic            ras_empty
);

  if (XLEN < 32 || (DELAY_SLOTS != 0 && DELAY_SLOTS != 1) || RAS_DEPTH < 2 ||
      (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_param_err
    $error("mips_cpu_bus_branch_unit: unsupported parameter set");
  end

  localparam bit HAS_SLOT = (DELAY_SLOTS != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [XLEN-1:0] target_r;
  logic            redirect_r;
  logic [XLEN-1:0] redirect_pc_r;
  logic            addr_err_r;
  logic            slot_err_r;

  logic [5:0]      op_s;
  logic [5:0]      fn_s;
  logic [4:0]      rt_f_s;
  logic            is_jr_s;
  logic            is_jalr_s;
  logic            is_jmp_s;
  logic            is_jal_s;
  logic            is_br_s;
  logic            is_bal_s;
  logic            br_cond_s;
  logic            rs_neg_s;
  logic            rs_zero_s;
  logic            is_ctl_s;
  logic            misal_s;
  logic            taken_s;
  logic [XLEN-1:0] pc4_s;
  logic [XLEN-1:0] br_tgt_s;
  logic [XLEN-1:0] jmp_tgt_s;
  logic [XLEN-1:0] tgt_s;
  logic            link_cand_s;
  logic [4:0]      dest_s;
  logic            acc_s;
  logic            in_slot_s;
  logic            link_en_s;
  logic            fire_s;
  logic [XLEN-1:0] fire_pc_s;
  logic            latch_s;
  logic            aerr_s;
  logic            serr_s;

  assign op_s      = instr[31:26];
  assign fn_s      = instr[5:0];
  assign rt_f_s    = instr[20:16];
  assign rs_neg_s  = rs_data[XLEN-1];
  assign rs_zero_s = (rs_data == {XLEN{1'b0}});

  // Opcode decode and branch condition evaluation
  always_comb begin
    is_jr_s   = 1'b0;
    is_jalr_s = 1'b0;
    is_jmp_s  = 1'b0;
    is_jal_s  = 1'b0;
    is_br_s   = 1'b0;
    is_bal_s  = 1'b0;
    br_cond_s = 1'b0;
    case (op_s)
      6'd0: begin
        case (fn_s)
          6'd8:    is_jr_s   = 1'b1;
          6'd9:    is_jalr_s = 1'b1;
          default: is_jr_s   = 1'b0;
        endcase
      end
      6'd1: begin
        case (rt_f_s)
          5'd0: begin
            is_br_s   = 1'b1;
            br_cond_s = rs_neg_s;
          end
          5'd1: begin
            is_br_s   = 1'b1;
            br_cond_s = ~rs_neg_s;
          end
          5'd16: begin
            is_br_s   = 1'b1;
            is_bal_s  = 1'b1;
            br_cond_s = rs_neg_s;
          end
          5'd17: begin
            is_br_s   = 1'b1;
            is_bal_s  = 1'b1;
            br_cond_s = ~rs_neg_s;
          end
          default: is_br_s = 1'b0;
        endcase
      end
      6'd2: is_jmp_s = 1'b1;
      6'd3: begin
        is_jmp_s = 1'b1;
        is_jal_s = 1'b1;
      end
      6'd4: begin
        is_br_s   = 1'b1;
        br_cond_s = (rs_data == rt_data);
      end
      6'd5: begin
        is_br_s   = 1'b1;
        br_cond_s = (rs_data != rt_data);
      end
      6'd6: begin
        is_br_s   = 1'b1;
        br_cond_s = rs_neg_s | rs_zero_s;
      end
      6'd7: begin
        is_br_s   = 1'b1;
        br_cond_s = ~rs_neg_s & ~rs_zero_s;
      end
      default: is_br_s = 1'b0;
    endcase
  end

  assign pc4_s     = pc + XLEN'(32'd4);
  assign br_tgt_s  = pc4_s + {{(XLEN-18){instr[15]}}, instr[15:0], 2'b00};
  assign jmp_tgt_s = {pc4_s[XLEN-1:28], instr[25:0], 2'b00};

  assign is_ctl_s    = is_jr_s | is_jalr_s | is_jmp_s | is_br_s;
  // A misaligned register target is reported and the jump is dropped
  assign misal_s     = (is_jr_s | is_jalr_s) & (rs_data[1:0] != 2'b00);
  assign taken_s     = is_jmp_s | (is_br_s & br_cond_s) | ((is_jr_s | is_jalr_s) & ~misal_s);
  assign tgt_s       = (is_jr_s | is_jalr_s) ? rs_data : (is_jmp_s ? jmp_tgt_s : br_tgt_s);
  assign link_cand_s = is_jal_s | is_jalr_s | is_bal_s;
  assign dest_s      = is_jalr_s ? instr[15:11] : 5'd31;

  assign acc_s     = instr_valid & ~stall & ~redirect_r;
  assign in_slot_s = (state_r == ST_PEND);
  assign link_en_s = acc_s & link_cand_s & ~in_slot_s;

  assign link_en   = link_en_s;
  assign link_dest = link_en_s ? dest_s : 5'd0;
  assign link_data = pc + XLEN'(32'd8);

  // Delay-slot sequencing: decide redirect, target latch and error pulses
  always_comb begin
    state_nxt_s = state_r;
    fire_s      = 1'b0;
    fire_pc_s   = target_r;
    latch_s     = 1'b0;
    aerr_s      = 1'b0;
    serr_s      = 1'b0;
    if (acc_s) begin
      if (in_slot_s) begin
        fire_s      = 1'b1;
        fire_pc_s   = target_r;
        serr_s      = is_ctl_s;
        state_nxt_s = ST_IDLE;
      end else begin
        aerr_s = misal_s;
        if (taken_s && HAS_SLOT) begin
          latch_s     = 1'b1;
          state_nxt_s = ST_PEND;
        end else if (taken_s) begin
          fire_s    = 1'b1;
          fire_pc_s = tgt_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, latched target, redirect handshake and error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      target_r      <= {XLEN{1'b0}};
      redirect_r    <= 1'b0;
      redirect_pc_r <= {XLEN{1'b0}};
      addr_err_r    <= 1'b0;
      slot_err_r    <= 1'b0;
    end else begin
      addr_err_r <= aerr_s;
      slot_err_r <= serr_s;
      if (!stall) begin
        state_r    <= state_nxt_s;
        redirect_r <= fire_s;
        if (fire_s) begin
          redirect_pc_r <= fire_pc_s;
        end
        if (latch_s) begin
          target_r <= tgt_s;
        end
      end
    end
  end

  assign redirect     = redirect_r;
  assign redirect_pc  = redirect_pc_r;
  assign slot_pending = in_slot_s;
  assign addr_err     = addr_err_r;
  assign slot_err     = slot_err_r;

`ifdef BRANCH_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1'b1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(RAS_DEPTH);

  logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
  logic [PW-1:0]   ras_top_r;
  logic [PW:0]     ras_cnt_r;
  logic            ras_misp_r;
  logic            pop_cand_s;
  logic            pop_s;
  logic            push_s;
  logic [PW-1:0]   top_m1_s;
  logic [PW-1:0]   top_pop_s;
  logic [PW:0]     cnt_pop_s;
  logic            misp_s;

  assign pop_cand_s = (is_jr_s | is_jalr_s) & (instr[25:21] == 5'd31);
  assign pop_s      = acc_s & ~in_slot_s & pop_cand_s & (ras_cnt_r != {(PW+1){1'b0}});
  assign push_s     = link_en_s;
  assign top_m1_s   = ras_top_r - PTR_ONE;
  // Pop is applied before push so JALR $31 -> $31 replaces the top entry
  assign top_pop_s  = pop_s ? top_m1_s : ras_top_r;
  assign cnt_pop_s  = pop_s ? (ras_cnt_r - CNT_ONE) : ras_cnt_r;
  assign misp_s     = pop_s & (ras_mem_r[top_m1_s] != rs_data);

  // Return-address storage, written at the post-pop top
  always_ff @(posedge clk) begin
    if (push_s) begin
      ras_mem_r[top_pop_s] <= link_data;
    end
  end

  // Stack pointer, occupancy and mispredict pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_top_r  <= {PW{1'b0}};
      ras_cnt_r  <= {(PW+1){1'b0}};
      ras_misp_r <= 1'b0;
    end else begin
      ras_misp_r <= misp_s;
      if (push_s) begin
        ras_top_r <= top_pop_s + PTR_ONE;
        ras_cnt_r <= (cnt_pop_s == CNT_FULL) ? CNT_FULL : (cnt_pop_s + CNT_ONE);
      end else begin
        ras_top_r <= top_pop_s;
        ras_cnt_r <= cnt_pop_s;
      end
    end
  end

  assign ras_mispredict = ras_misp_r;
  assign ras_empty      = (ras_cnt_r == {(PW+1){1'b0}});
`else
  assign ras_mispredict = 1'b0;
  assign ras_empty      = 1'b1;
`endif

endmodule

// File: doc/mips_cpu_bus_branch_unit.md
# mips_cpu_bus_branch_unit

Registered branch/jump resolution unit for the bus-based MIPS core, sitting between decode/execute and the fetch PC register. It generalises combinational branch decode with:
- proper sign-extended offsets and delay-slot sequencing (0 or 1 slot);
- a stall-aware redirect handshake toward fetch;
- misaligned-target detection;
- an optional return-address stack (RAS) that checks `JR $31` targets.

## Interface
Parameters:
- `XLEN`, 32: datapath/address width; must be ≥ 32.
- `DELAY_SLOTS`, 1: 0 or 1; number of instructions executed after a taken branch before redirect.
- `RAS_DEPTH`, 4: RAS entries, power of two ≥ 2; used only with `BRANCH_RAS_EN`.

Ports:
- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst_n` in 1: reset; synchronous, active-low.
- `instr_valid` in 1: `instr` / `pc` / `rs_data` / `rt_data` hold a decoded instruction this cycle.
- `stall` in 1: bus wait; when high, no instruction is accepted and all state holds.
- `instr` in 32: instruction word.
- `pc` in XLEN: address of `instr`.
- `rs_data`, `rt_data` in XLEN: register operands.
- `link_en` out 1: combinational; write `link_data` to `link_dest` this cycle.
- `link_dest` out 5: link register index.
- `link_data` out XLEN: `pc + 8`.
- `redirect` out 1: registered; fetch must load `redirect_pc`.
- `redirect_pc` out XLEN: registered target.
- `slot_pending` out 1: a taken branch awaits its delay-slot instruction.
- `addr_err` out 1: registered one-cycle pulse; JR/JALR target had `[1:0] != 0`.
- `slot_err` out 1: registered one-cycle pulse; branch/jump found in a delay slot.
- `ras_mispredict` out 1: registered one-cycle pulse (RAS only).
- `ras_empty` out 1: RAS holds no entries (RAS only).

## Operation
- **Accept condition:** `acc = instr_valid & ~stall & ~redirect`. While `redirect` is high, instructions are wrong-path and ignored entirely: no link, no state change.
- **Decode set:**
  - JR (op 0 / fn 8), JALR (op 0 / fn 9, dest `instr[15:11]`);
  - J (2), JAL (3, dest 31);
  - BEQ (4), BNE (5), BLEZ (6), BGTZ (7);
  - REGIMM (op 1) by `instr[20:16]`: BLTZ 0, BGEZ 1, BLTZAL 16, BGEZAL 17 (both AL forms dest 31).
  - All other encodings: not a branch.
- **Conditions:**
  - BEQ/BNE compare `rs_data` with `rt_data`.
  - BLEZ/BGTZ/BLTZ/BGEZ use signed `rs_data`.
- **Targets (all mod 2^XLEN):**
  - Branches: `pc + 4 + (sext(instr[15:0]) << 2)`.
  - J/JAL: `{(pc+4)[XLEN-1:28], instr[25:0], 2'b00}`.
  - JR/JALR: `rs_data`.
- **Link:** `link_en = acc & (JAL | JALR | BxxAL)`. BxxAL links whether or not the branch is taken (MIPS-I). `link_dest = 0` and `link_data = pc + 8` when not linking.
- **JR/JALR misaligned** (`rs_data[1:0] != 0`): `addr_err` pulses and the branch is treated as not taken. JALR still links.
- **Delay slot:** state machine IDLE → PEND → (redirect) → IDLE.
  - **`DELAY_SLOTS = 1`:** a taken branch accepted in IDLE latches its target and moves to PEND (`slot_pending = 1`). The next accept in PEND is the slot instruction. It executes normally (links allowed), except that any branch/jump in it is ignored for control flow, its link is suppressed, and `slot_err` pulses. That accept raises `redirect` with the latched target and returns to IDLE.
  - **`DELAY_SLOTS = 0`:** a taken branch raises `redirect` directly from IDLE; PEND is never entered.
- **Redirect handshake:** `redirect` and `redirect_pc` assert after the triggering edge. They hold stable while `stall = 1` and deassert after the first clock edge with `stall = 0`.
- **Reset:** synchronous, usable mid-operation.
  - Outputs return to 0: `redirect`, `redirect_pc`, `slot_pending`, `addr_err`, `slot_err`, `ras_mispredict`.
  - `ras_empty` returns to 1.
  - Any pending target is discarded and the RAS is emptied.

## Timing
- `link_*` are combinational from the inputs (same cycle as acceptance).
- `redirect` appears one cycle after the accepting edge of the trigger instruction: the branch itself (0 slots) or the delay-slot instruction (1 slot).
- `addr_err`, `slot_err`, `ras_mispredict` are one cycle wide and appear one cycle after the accepting edge.
- Throughput: one instruction per non-stalled cycle. After each taken branch, exactly one cycle is lost to the `redirect` squash.

## Configuration
- **`BRANCH_RAS_EN` defined:** a circular RAS of `RAS_DEPTH` entries.
  - **Push** `pc + 8` on every accepted linking instruction whose link is not suppressed. When full, the oldest entry is overwritten.
  - **Pop** on an accepted JR with `instr[25:21] == 31`. If the stack was non-empty and the popped value differs from `rs_data`, `ras_mispredict` pulses. A pop when empty does nothing.
  - **Same-cycle push and pop:** only possible for JALR $31 → $31. It is handled as pop-then-push.
- **`BRANCH_RAS_EN` undefined:** no RAS storage is built; `ras_mispredict = 0` and `ras_empty = 1` constantly.

## Test plan
- BEQ at `pc = 0x1000`, `imm = 0xFFFE`, `rs = rt = 5`, `DELAY_SLOTS = 1`: `slot_pending = 1` next cycle. After the slot instruction is accepted, `redirect = 1`, `redirect_pc = 0x0FFC`. The following `instr_valid` is ignored.
- JAL `idx = 0x0100000` at `pc = 0xBFC00010`: `link_en = 1`, `link_dest = 31`, `link_data = 0xBFC00018`. After the slot, `redirect_pc = 0xB0400000`.
- BLTZAL with `rs = 0x00000001` (not taken): `link_en = 1`, `link_data = pc + 8`, no `redirect`, `slot_pending` stays 0.
- JR with `rs = 0x00001002`: `addr_err` pulses once, no `redirect`. `stall` held high 3 cycles during a pending redirect: `redirect_pc` stays stable all 3 cycles, then drops one edge after `stall` falls.
- Reset asserted while `slot_pending = 1`: next cycle all outputs are 0 (`ras_empty = 1`), and the slot instruction then accepted causes no `redirect`.
- `BRANCH_RAS_EN`, `RAS_DEPTH = 4`: five JALs push entries; five `JR $31` pops with matching targets give no mispredict for the four newest. The fifth pop finds the stack empty, so no mispredict and `ras_empty = 1`. A mismatched `rs` on an earlier pop pulses `ras_mispredict` once.
